matrix_op_sequencer: RTL

MATRIX_OP_SEQUENCER -- requirements
Module: matrix_op_sequencer

---
 rtl/matrix_op_sequencer.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/matrix_op_sequencer.sv
// Sequences a 5x5 matrix op: loads operand pairs from memory, runs the external ALU, stores the result block.
// done asserts 2*N_ELEM+MEM_RD_LAT+ALU_WAIT edges after the accepted start; abort returns to IDLE on the next edge.
module matrix_op_sequencer #(
    parameter int N_ELEM     = 25,
    parameter int RES_BASE   = 25,
    parameter int MEM_RD_LAT = 2,
    parameter int ALU_WAIT   = 70
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [2:0]            op_code,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf_flag,
    output logic [2:0]            state_dbg,
    output logic [6:0]            mem_addr,
    output logic                  mem_wren,
    output logic [15:0]           mem_wdata,
    input  logic [15:0]           mem_rdata,
    output logic [2:0]            alu_op,
    output logic [8*N_ELEM-1:0]   alu_a,
    output logic [8*N_ELEM-1:0]   alu_b,
    output logic                  alu_start,
    input  logic [8*N_ELEM-1:0]   alu_result,
    input  logic                  alu_overflow
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_WAIT  = 3'd2,
        S_STORE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [7:0] LOAD_LAST  = 8'(N_ELEM + MEM_RD_LAT - 1);
    localparam logic [7:0] WAIT_LAST  = 8'(ALU_WAIT - 1);
    localparam logic [7:0] STORE_LAST = 8'(N_ELEM - 1);
    localparam logic [7:0] N_ELEM8    = 8'(N_ELEM);
    localparam logic [7:0] RD_LAT8    = 8'(MEM_RD_LAT);
    localparam logic [6:0] RES_BASE7  = 7'(RES_BASE);

    state_t                 r_state;
    state_t                 w_next;
    logic [7:0]             r_cnt;
    logic [7:0]             w_cnt_nxt;
    logic [2:0]             r_op;
    logic                   r_ovf;
    logic [8*N_ELEM-1:0]    r_a;
    logic [8*N_ELEM-1:0]    r_b;
    logic [8*N_ELEM-1:0]    r_res;
    logic [7:0]             w_ld_idx;
    logic [7:0]             w_res_elem;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start && !abort)       w_next = S_LOAD;
            S_LOAD:  if (r_cnt == LOAD_LAST)    w_next = S_WAIT;
            S_WAIT:  if (r_cnt == WAIT_LAST)    w_next = S_STORE;
            S_STORE: if (r_cnt == STORE_LAST)   w_next = S_DONE;
            S_DONE:                             w_next = S_IDLE;
            default:                            w_next = S_IDLE;
        endcase
        if (r_state != S_IDLE && abort) begin
            w_next = S_IDLE;
        end
        // One counter serves every phase; it restarts on each state change.
        w_cnt_nxt = (w_next != r_state || r_state == S_IDLE) ? 8'd0 : r_cnt + 8'd1;
    end

    assign w_ld_idx = r_cnt - RD_LAT8;

    always_comb begin
        w_res_elem = 8'd0;
        for (int k = 0; k < N_ELEM; k++) begin
            if (r_cnt == 8'(k)) begin
                w_res_elem = r_res[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
            r_op    <= 3'd0;
            r_ovf   <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_nxt;
            if (r_state == S_IDLE && w_next == S_LOAD) begin
                r_op  <= op_code;
                r_ovf <= 1'b0;
            end
            // Read data lags the issued address by MEM_RD_LAT cycles.
            if (r_state == S_LOAD && r_cnt >= RD_LAT8) begin
                for (int k = 0; k < N_ELEM; k++) begin
                    if (w_ld_idx == 8'(k)) begin
                        r_a[8*k +: 8] <= mem_rdata[7:0];
                        r_b[8*k +: 8] <= mem_rdata[15:8];
                    end
                end
            end
            if (r_state == S_WAIT && r_cnt == WAIT_LAST && !abort) begin
                r_res <= alu_result;
                if (alu_overflow) begin
                    r_ovf <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        busy      = (r_state != S_IDLE);
        done      = (r_state == S_DONE) && !abort;
        alu_start = (r_state == S_WAIT) && (r_cnt == 8'd0) && !abort;
        mem_addr  = 7'd0;
        mem_wren  = 1'b0;
        mem_wdata = 16'd0;
        if (r_state == S_LOAD && r_cnt < N_ELEM8) begin
            mem_addr = r_cnt[6:0];
        end
        // An abort in STORE suppresses the write of the current element.
        if (r_state == S_STORE && !abort) begin
            mem_wren  = 1'b1;
            mem_addr  = RES_BASE7 + r_cnt[6:0];
            mem_wdata = {8'h00, w_res_elem};
        end
    end

    assign state_dbg = r_state;
    assign alu_op    = r_op;
    assign alu_a     = r_a;
    assign alu_b     = r_b;
    assign ovf_flag  = r_ovf;

endmodule
